mem_lsu: RTL
============

# mem_lsu

Load/store unit between the core's memory-request port and the word-organised data RAM. It turns byte-addressed byte/halfword/word accesses into single-word RAM transactions. Sub-word stores use a read-modify-write sequence. It checks alignment and the RAM address window, and returns one aligned, extended result per request.

## Interface
Parameters:
- RAM_BASE_WORD, 256, first valid word address of the RAM window
- RAM_WORDS, 256, number of words in the window

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted on an edge where req_valid && req_ready
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved (error)
- req_signed  in  1  sign-extend a load (ignored for word loads and stores)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle response pulse, no backpressure
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_err  out  1  misaligned, reserved size, or out of window
- ram_addr  out  32  word address, {2'b00, addr[31:2]}
- ram_data_in  out  32  write data to the RAM
- ram_data_out  in  32  RAM read data, valid the cycle after a read edge
- ram_read  out  1  1 = read, 0 = write
- ram_en  out  1  RAM access strobe

## Operation
- Request fields are latched at the acceptance edge A.
- req_ready is 1 only when the state is IDLE and rst_n is high.
- Error is checked at acceptance:
  - size 3 is an error.
  - half with addr[0] = 1 is an error.
  - word with addr[1:0] != 0 is an error.
  - addr[31:2] outside [RAM_BASE_WORD, RAM_BASE_WORD+RAM_WORDS) is an error.
  - On error, ram_en is never asserted for that request.
- FSM states: IDLE, RD, LD_DATA, ST_WORD, RMW, ERR.
  - IDLE → ERR on an error request.
  - IDLE → RD for a load or a sub-word store.
  - IDLE → ST_WORD for a word store.
  - RD → LD_DATA for a load; RD → RMW for a sub-word store.
  - LD_DATA, ST_WORD, RMW and ERR each → IDLE.
- RD: ram_en = 1, ram_read = 1.
- ST_WORD: ram_en = 1, ram_read = 0, ram_data_in = wdata.
- RMW: ram_en = 1, ram_read = 0, ram_data_in = ram_data_out with the addressed lanes replaced (combinational merge).
- Lane selection is little-endian: byte lane = addr[1:0], half lane = addr[1].
- Load extract:
  - Select the addressed lane.
  - Zero- or sign-extend it to 32 bits per req_signed.
- ram_en, ram_read, ram_data_in and ram_addr are decoded from the state and the latched request.
- ram_addr is held stable through RD→RMW.
- resp_valid, resp_rdata and resp_err are registered and are set on the edge that leaves LD_DATA, ST_WORD, RMW or ERR.

## Timing
- Latencies from acceptance edge A (resp_valid high during the cycle after edge X):
  - Load: RAM read at A+1, resp_valid after A+2.
  - Word store: RAM write at A+1, resp_valid after A+1.
  - Sub-word store: RAM read at A+1, RAM write at A+2, resp_valid after A+2.
  - Error: resp_valid after A+1, no RAM activity.
- A new request can be accepted in the same cycle that resp_valid is high. Back-to-back throughput is therefore one request per 2 cycles (word store, error) or per 3 cycles (load, sub-word store).
- Reset values:
  - state = IDLE.
  - resp_valid, resp_rdata and resp_err = 0.
  - Latched request = 0, so ram_addr = 0 and ram_data_in = 0.
  - ram_en = 0 and ram_read = 0; req_ready = 0.
- Reset mid-operation: the state returns to IDLE immediately and ram_en drops asynchronously. An RMW interrupted before its A+2 edge performs no write. No response is issued for an aborted request.
- On wrap-around at the window top, word address 511 is valid and 512 is an error.

## Structure
- Package mem_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - the state encoding;
  - the default RAM_BASE_WORD and RAM_WORDS constants.
- Sub-module lsu_align is purely combinational. It takes a word, addr[1:0], size and signed flag, and produces the load extract/extend result and the store lane merge. It is instantiated once for the load path and once for the store path, or once with a mode select.

## Test plan
- Word store 0xDEADBEEF @0x400, then word load @0x400:
  - RAM write at A+1, resp_valid after A+1.
  - Load returns 0xDEADBEEF, err = 0, resp_valid after A+2.
- Word store 0x11223344 @0x404, then byte store 0xA5 @0x405:
  - Word 257 becomes 0x1122A544.
  - Signed byte load @0x405 returns 0xFFFFFFA5; unsigned returns 0x000000A5.
- Half store 0x8001 @0x40A on zeroed RAM:
  - Word 258 becomes 0x80010000.
  - Signed half load @0x40A returns 0xFFFF8001; unsigned returns 0x00008001.
- Each of the following gives resp_err = 1, rdata = 0, resp_valid after A+1, and ram_en never high:
  - word load @0x402;
  - half load @0x401;
  - size 3 request;
  - load @0x3FC;
  - load @0x800.
- Reset during a sub-word store: word store 0xCAFEF00D @0x410, byte store 0x00 @0x410, then drop rst_n in the cycle after A.
  - Word 260 stays 0xCAFEF00D.
  - No resp_valid is issued.
  - req_ready is 1 in the first cycle after rst_n rises.
- Back-to-back: hold req_valid high with a word store followed by a load to the same address.
  - The second request is accepted in the resp_valid cycle of the first.
  - The load returns the stored data.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared size/state encodings, window defaults and request legality check for mem_lsu
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    localparam int unsigned DEF_RAM_BASE_WORD = 256;
    localparam int unsigned DEF_RAM_WORDS     = 256;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_LD_DATA,
        S_ST_WORD,
        S_RMW,
        S_ERR
    } state_e;

    // A request is illegal if its size is reserved, it is misaligned, or its word is outside the window
    function automatic logic req_bad(input logic [1:0] size, input logic [31:0] addr,
                                     input int unsigned base, input int unsigned words);
        logic [31:0] w;
        w = {2'b00, addr[31:2]};
        return size == SZ_RSVD || (size == SZ_HALF && addr[0]) ||
               (size == SZ_WORD && addr[1:0] != 2'b00) || w < base || w >= base + words;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: little-endian lane extract/extend for loads and lane merge for sub-word stores
module lsu_align
    import mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] store_o
);

    logic [4:0]  sh;
    logic [31:0] mask;
    logic [31:0] lane_w;

    // Shift the addressed lane down for loads, and splice right-aligned store data into it
    always_comb begin
        sh      = size_i == SZ_BYTE ? {lane_i, 3'b000} : size_i == SZ_HALF ? {lane_i[1], 4'b0000} : 5'd0;
        mask    = size_i == SZ_BYTE ? 32'h0000_00FF : size_i == SZ_HALF ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        lane_w  = word_i >> sh;
        load_o  = size_i == SZ_BYTE ? {{24{signed_i & lane_w[7]}}, lane_w[7:0]} :
                  size_i == SZ_HALF ? {{16{signed_i & lane_w[15]}}, lane_w[15:0]} : word_i;
        store_o = (word_i & ~(mask << sh)) | ((wdata_i & mask) << sh);
    end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: byte/half/word load-store unit over a word RAM, with read-modify-write for sub-word stores
module mem_lsu
    import mem_pkg::*;
#(
    parameter int unsigned RAM_BASE_WORD = DEF_RAM_BASE_WORD,
    parameter int unsigned RAM_WORDS     = DEF_RAM_WORDS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_data_in,
    input  logic [31:0] ram_data_out,
    output logic        ram_read,
    output logic        ram_en
);

    state_e      state_q, state_d;
    logic        write_q, signed_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        accept, bad;
    logic [31:0] load_data, store_data;

    assign req_ready   = state_q == S_IDLE && rst_n;
    assign accept      = req_valid && req_ready;
    assign bad         = req_bad(req_size, req_addr, RAM_BASE_WORD, RAM_WORDS);
    assign ram_en      = state_q == S_RD || state_q == S_ST_WORD || state_q == S_RMW;
    assign ram_read    = state_q == S_RD;
    assign ram_addr    = {2'b00, addr_q[31:2]};
    assign ram_data_in = state_q == S_RMW ? store_data : wdata_q;
    assign resp_valid  = resp_valid_q;
    assign resp_err    = resp_err_q;
    assign resp_rdata  = resp_rdata_q;

    lsu_align u_align (
        .word_i   (ram_data_out),
        .lane_i   (addr_q[1:0]),
        .size_i   (size_q),
        .signed_i (signed_q),
        .wdata_i  (wdata_q),
        .load_o   (load_data),
        .store_o  (store_data)
    );

    // Sequence each request through the FSM and form the response on leaving a terminal state
    always_comb begin
        state_d      = state_q == S_IDLE ? (accept ? (bad ? S_ERR :
                                                      (req_write && req_size == SZ_WORD) ? S_ST_WORD : S_RD) : S_IDLE) :
                       state_q == S_RD   ? (write_q ? S_RMW : S_LD_DATA) : S_IDLE;
        resp_valid_d = state_q == S_LD_DATA || state_q == S_ST_WORD || state_q == S_RMW || state_q == S_ERR;
        resp_err_d   = state_q == S_ERR;
        resp_rdata_d = state_q == S_LD_DATA ? load_data : 32'd0;
    end

    // State, latched request fields and registered response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            write_q      <= 1'b0;
            signed_q     <= 1'b0;
            size_q       <= 2'd0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            if (accept) begin
                write_q  <= req_write;
                signed_q <= req_signed;
                size_q   <= req_size;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
            end
        end
    end

endmodule
